// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for DIGITS common-anode 7-segment positions.
// Double-buffered BCD value, frame-boundary commit, per-slot blanking gap, optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  lz_blank,
    output logic [4:0]            num,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  load_ack,
    output logic                  frame_start
);

    localparam int unsigned VAL_W     = 4 * DIGITS;
    localparam int unsigned CNT_W     = $clog2(TICK_DIV);
    localparam int unsigned IDX_W     = $clog2(DIGITS);
    localparam logic [4:0]  NUM_BLANK = 5'd31;

    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [VAL_W-1:0]  r_pend_val;
    logic              r_pend_flag;
    logic [VAL_W-1:0]  r_disp_val;
    logic [4:0]        r_num;
    logic [DIGITS-1:0] r_dig_en;
    logic              r_load_ack;
    logic              r_frame_start;

    logic              w_tick;
    logic              w_boundary;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [VAL_W-1:0]  w_pend_val_nxt;
    logic              w_pend_flag_nxt;
    logic [VAL_W-1:0]  w_disp_val_nxt;
    logic              w_ack_nxt;
    logic [3:0]        w_nib;
    logic              w_suppress;
    logic [DIGITS-1:0] w_en_n;
    logic              w_blank_gap;
    logic [4:0]        w_num_nxt;
    logic [DIGITS-1:0] w_dig_en_nxt;

    // Prescaler and digit index; the wrap of the last digit is the frame boundary.
    always_comb begin
        w_tick     = (r_cnt == CNT_W'(TICK_DIV - 1));
        w_boundary = w_tick && (r_idx == IDX_W'(DIGITS - 1));
        w_cnt_nxt  = w_tick ? '0 : r_cnt + CNT_W'(1);
        w_idx_nxt  = r_idx;
        if (w_tick) begin
            w_idx_nxt = w_boundary ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Double buffer: a load on the boundary edge bypasses the pending slot.
    always_comb begin
        w_pend_val_nxt  = r_pend_val;
        w_pend_flag_nxt = r_pend_flag;
        w_disp_val_nxt  = r_disp_val;
        w_ack_nxt       = 1'b0;
        if (w_boundary) begin
            w_pend_flag_nxt = 1'b0;
            if (load) begin
                w_disp_val_nxt = bcd_in;
                w_ack_nxt      = 1'b1;
            end else if (r_pend_flag) begin
                w_disp_val_nxt = r_pend_val;
                w_ack_nxt      = 1'b1;
            end
        end else if (load) begin
            w_pend_val_nxt  = bcd_in;
            w_pend_flag_nxt = 1'b1;
        end
    end

    // Digit select, scanning from the top so the zero run covers every higher nibble.
    always_comb begin
        logic w_zero_run;
        w_zero_run = 1'b1;
        w_nib      = 4'd0;
        w_suppress = 1'b0;
        w_en_n     = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_disp_val[4*i +: 4] == 4'd0);
            if (r_idx == IDX_W'(i)) begin
                w_nib      = r_disp_val[4*i +: 4];
                w_en_n[i]  = 1'b0;
                w_suppress = lz_blank && (i > 0) && w_zero_run;
            end
        end
    end

    // Suppressed digits keep their enable so every position sees the same duty cycle.
    always_comb begin
        w_blank_gap  = (r_cnt < CNT_W'(BLANK_CYC));
        w_num_nxt    = {1'b0, w_nib};
        w_dig_en_nxt = w_en_n;
        if (w_blank_gap) begin
            w_num_nxt    = NUM_BLANK;
            w_dig_en_nxt = '1;
        end else if (w_suppress) begin
            w_num_nxt = NUM_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_pend_val    <= '0;
            r_pend_flag   <= 1'b0;
            r_disp_val    <= '0;
            r_num         <= NUM_BLANK;
            r_dig_en      <= '1;
            r_load_ack    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_pend_val    <= w_pend_val_nxt;
            r_pend_flag   <= w_pend_flag_nxt;
            r_disp_val    <= w_disp_val_nxt;
            r_num         <= w_num_nxt;
            r_dig_en      <= w_dig_en_nxt;
            r_load_ack    <= w_ack_nxt;
            r_frame_start <= w_boundary;
        end
    end

    assign num         = r_num;
    assign dig_en      = r_dig_en;
    assign load_ack    = r_load_ack;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (DIGITS=4, TICK_DIV=8, BLANK_CYC=2).
// Frame n occupies edges 32n+1..32n+32 after reset release; digit d of frame n is sampled at edge 32n+8d+5.
module tb_seg7_scan_ctrl;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned TICK_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                load;
    logic [4*DIGITS-1:0] bcd_in;
    logic                lz_blank;
    logic [4:0]          num;
    logic [DIGITS-1:0]   dig_en;
    logic                load_ack;
    logic                frame_start;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int ack_cnt   = 0;
    int multi_low = 0;
    int ack_base;

    seg7_scan_ctrl #(
        .DIGITS    (DIGITS),
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .bcd_in      (bcd_in),
        .lz_blank    (lz_blank),
        .num         (num),
        .dig_en      (dig_en),
        .load_ack    (load_ack),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (load_ack) ack_cnt++;
        if ($countones(~dig_en) > 1) multi_low++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic check_digit(input string tag, input int k, input int d, input logic [4:0] exp_num);
        logic [DIGITS-1:0] exp_en;
        run_to(k);
        exp_en    = '1;
        exp_en[d] = 1'b0;
        check_val({tag, "_en"}, 32'(dig_en), 32'(exp_en));
        check_val({tag, "_num"}, 32'(num), 32'(exp_num));
    endtask

    // Called right after release: 3 blank samples, 6 digit-0 samples showing 0, then blank again.
    task automatic check_startup(input string tag);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) tick();
            if (k < 3 || k == 9) begin
                check_val({tag, "_blank_en"}, 32'(dig_en), 32'hF);
                check_val({tag, "_blank_num"}, 32'(num), 32'd31);
            end else begin
                check_val({tag, "_d0_en"}, 32'(dig_en), 32'hE);
                check_val({tag, "_d0_num"}, 32'(num), 32'd0);
            end
        end
    endtask

    task automatic load_after(input int k, input logic [15:0] val);
        run_to(k);
        load   = 1'b1;
        bcd_in = val;
        tick();
        load   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        bcd_in   = '0;
        lz_blank = 1'b0;
        tick();
        tick();
        check_val("rst_en", 32'(dig_en), 32'hF);
        check_val("rst_num", 32'(num), 32'd31);
        check_val("rst_ack", 32'(load_ack), 32'd0);
        check_val("rst_fs", 32'(frame_start), 32'd0);
        rst = 1'b0;
        cyc = 0;
        check_startup("start");

        // Basic load in the idx=1 slot of frame 0.
        load_after(10, 16'h1234);
        run_to(31);
        check_val("basic_noack", 32'(ack_cnt), 32'd0);
        run_to(32);
        check_val("basic_ack", 32'(load_ack), 32'd1);
        check_val("basic_fs", 32'(frame_start), 32'd1);
        run_to(33);
        check_val("basic_ack_end", 32'(load_ack), 32'd0);
        check_val("basic_fs_end", 32'(frame_start), 32'd0);
        check_digit("f1d0", 37, 0, 5'd4);
        check_digit("f1d1", 45, 1, 5'd3);
        check_digit("f1d2", 53, 2, 5'd2);
        check_digit("f1d3", 61, 3, 5'd1);

        // Leading-zero suppression.
        run_to(64);
        lz_blank = 1'b1;
        load_after(70, 16'h0050);
        run_to(96);
        check_val("lz_ack", 32'(load_ack), 32'd1);
        check_digit("lz50d0", 101, 0, 5'd0);
        check_digit("lz50d1", 109, 1, 5'd5);
        check_digit("lz50d2", 117, 2, 5'd31);
        check_digit("lz50d3", 125, 3, 5'd31);
        load_after(110, 16'h0000);
        check_digit("lz0d0", 133, 0, 5'd0);
        check_digit("lz0d1", 141, 1, 5'd31);
        check_digit("lz0d2", 149, 2, 5'd31);
        check_digit("lz0d3", 157, 3, 5'd31);

        // Last load in a frame wins, one ack only.
        run_to(160);
        lz_blank = 1'b0;
        ack_base = ack_cnt;
        load_after(162, 16'h1111);
        load_after(170, 16'h2222);
        check_digit("lw_d0", 197, 0, 5'd2);
        check_digit("lw_d1", 205, 1, 5'd2);
        check_digit("lw_d2", 213, 2, 5'd2);
        check_digit("lw_d3", 221, 3, 5'd2);
        check_val("lw_one_ack", 32'(ack_cnt - ack_base), 32'd1);

        // Load captured on the boundary edge itself.
        load_after(223, 16'h9876);
        check_val("bnd_ack", 32'(load_ack), 32'd1);
        check_val("bnd_fs", 32'(frame_start), 32'd1);
        check_digit("bnd_d0", 229, 0, 5'd6);
        check_digit("bnd_d3", 253, 3, 5'd9);

        // Asynchronous reset with a load pending, mid digit-1 slot.
        load_after(260, 16'h5555);
        run_to(270);
        ack_base = ack_cnt;
        rst = 1'b1;
        #1;
        check_val("mid_rst_en", 32'(dig_en), 32'hF);
        check_val("mid_rst_num", 32'(num), 32'd31);
        check_val("mid_rst_ack", 32'(load_ack), 32'd0);
        tick();
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        check_startup("rerun");
        run_to(32);
        check_val("rr_noack", 32'(load_ack), 32'd0);
        check_val("rr_fs", 32'(frame_start), 32'd1);
        check_digit("rr_d0", 37, 0, 5'd0);
        check_digit("rr_d1", 45, 1, 5'd0);
        check_digit("rr_d2", 53, 2, 5'd0);
        check_digit("rr_d3", 61, 3, 5'd0);
        run_to(70);
        check_val("rr_ack_total", 32'(ack_cnt - ack_base), 32'd0);
        check_val("one_hot_low", 32'(multi_low), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller that shares one `seg_7` decoder across `DIGITS` common-anode digit positions. It holds a double-buffered BCD display value and steps a one-hot active-low digit enable through the positions at a programmable slot rate. Each slot starts with a ghost-suppression blanking gap. New values are accepted on a load strobe and committed only at a frame boundary, so the display never shows a mix of old and new digits. It sits between the UART receive path (value producer) and the board display pins.

## Interface
- `DIGITS`, 4: number of multiplexed digit positions, legal range 2..8.
- `TICK_DIV`, 50000: `clk` cycles per digit slot; must satisfy `TICK_DIV >= BLANK_CYC + 2`.
- `BLANK_CYC`, 16: cycles at the start of each slot with all digits off; must be `>= 1`.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `load`  in  1  single-cycle strobe that captures `bcd_in`.
- `bcd_in`  in  4*DIGITS  BCD value; nibble 0 (`[3:0]`) is the rightmost digit.
- `lz_blank`  in  1  enables leading-zero suppression when 1.
- `num`  out  5  decoder code for the active digit; 31 means blank.
- `dig_en`  out  DIGITS  active-low one-hot digit enable; all 1s means every digit is off.
- `load_ack`  out  1  one-cycle pulse when a captured value is committed to display.
- `frame_start`  out  1  one-cycle pulse at the start of each digit-0 slot.

## Operation
- State: prescaler `cnt` (0..TICK_DIV-1), digit index `idx` (0..DIGITS-1), `pend_val`/`pend_flag`, `disp_val`.
- `cnt` increments every cycle. On `cnt==TICK_DIV-1`:
  - `cnt` wraps to 0.
  - `idx` advances, wrapping from DIGITS-1 to 0.
- The wrap from DIGITS-1 to 0 is the frame boundary. On the boundary edge:
  - if `pend_flag` is set, `disp_val<=pend_val`, `pend_flag<=0`, and `load_ack` pulses;
  - `frame_start` pulses.
- `load` with no boundary on the same edge: `pend_val<=bcd_in`, `pend_flag<=1`. A later load in the same frame overwrites (last wins); only one ack is issued.
- `load` on the boundary edge: `disp_val<=bcd_in` directly, `pend_flag<=0`, and `load_ack` pulses.
- Output decode, registered:
  - `cnt<BLANK_CYC`: `dig_en` all 1s, `num=31`.
  - otherwise: `dig_en[idx]=0` with all other bits 1, and `num={1'b0, disp_val nibble idx}`.
- Nibbles 10..15 pass through unchanged; the decoder blanks them.
- Leading-zero suppression (`lz_blank=1`): digit i>0 is blanked when nibble i and every higher nibble are 0.
  - A blanked digit drives `num=31` but keeps `dig_en` asserted, so duty cycle stays uniform.
  - Digit 0 is never suppressed.
- Asynchronous reset mid-operation:
  - pending load is discarded with no ack;
  - `disp_val` returns to 0;
  - scanning restarts at digit 0.

## Timing
- Reset values:
  - outputs: `dig_en` all 1s, `num=31`, `load_ack=0`, `frame_start=0`;
  - state: `cnt=0`, `idx=0`, `disp_val=0`, `pend_flag=0`.
- All outputs are registered and lag `cnt`/`idx` by one cycle.
- After reset release:
  - the first slot is digit 0;
  - `dig_en` stays all 1s for the first `BLANK_CYC+1` cycles;
  - then `dig_en[0]=0` for `TICK_DIV-BLANK_CYC` cycles.
- Slot period is exactly `TICK_DIV` cycles; frame period is `DIGITS*TICK_DIV` cycles. These must hold with no drift.
- `frame_start` and `load_ack` assert in the cycle after the boundary edge. They coincide when a commit happens.
- Worst-case latency from `load` to ack is one frame plus 1 cycle.
- No cycle ever has two `dig_en` bits low.

## Test plan
Bench parameters: `DIGITS=4`, `TICK_DIV=8`, `BLANK_CYC=2`.

1. **Reset:** hold `rst=1` mid-slot -> outputs go immediately to `dig_en=4'b1111`, `num=31`, `load_ack=0`. After release with `lz_blank=0` -> 3 blank cycles, then `dig_en=4'b1110`, `num=0` for 6 cycles.
2. **Basic load:** `load` with `bcd_in=16'h1234` in the idx=1 slot -> no ack until the boundary, then one `load_ack` pulse together with `frame_start`. The following frame shows `num` 4,3,2,1 with `dig_en` 1110,1101,1011,0111.
3. **Leading zeros:** `lz_blank=1`, committed value `16'h0050` -> digits 3 and 2 give `num=31` with `dig_en` low; digit 1 gives `num=5`; digit 0 gives `num=0`. Value `16'h0000` -> only digit 0 shows 0.
4. **Last-wins:** loads of `16'h1111` then `16'h2222` in one frame -> exactly one `load_ack`, display shows 2 on all digits.
5. **Load on boundary:** `load` with `16'h9876` on the boundary edge -> `load_ack` in the next cycle, and the digit-0 slot of that same frame shows `num=6`.
6. **Reset mid-operation:** assert `rst` while `pend_flag=1` -> no `load_ack` is ever produced, and after release the display reads `16'h0000`.
